// File: rtl/synth_pkg.sv
// Shared constants, per-voice phase increments and FSM state encoding for the voice sequencer.
package synth_pkg;

   localparam int NUM_VOICES = 8;
   localparam int PHASE_W    = 32;

   // Entry v is the phase increment of voice v (voice 0 is the rightmost word).
   localparam logic [NUM_VOICES-1:0][PHASE_W-1:0] INC_TABLE = {
      32'd22473, 32'd21212, 32'd18898, 32'd16836,
      32'd14999, 32'd14157, 32'd12613, 32'd11237
   };

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } seq_state_e;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: counts 0..SAMPLE_DIV-1 and flags the last count as a one-cycle tick.
module sample_tick_gen #(
   parameter int SAMPLE_DIV = 6104
) (
   input  logic clk_in,
   input  logic rst_n_in,
   output logic tick_out
);

   localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_out = (cnt_q == LAST);
      cnt_d    = tick_out ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/voice_sequencer.sv
// Eight-voice phase-accumulator sequencer sharing one sine ROM; mixes one sample per divider tick.
//
// state | meaning
// IDLE  | waiting for the sample tick
// ISSUE | 8 cycles, slot v updates voice v and may issue a ROM read
// DRAIN | ROM_LATENCY cycles collecting the outstanding ROM returns
// DONE  | one cycle, publishes the mixed sample
module voice_sequencer
   import synth_pkg::*;
#(
   parameter int SAMPLE_DIV  = 6104,
   parameter int ROM_LATENCY = 2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [7:0]  gate_in,
   input  logic [7:0]  trigger_in,
   output logic        rom_req_out,
   output logic [7:0]  rom_addr_out,
   input  logic [15:0] rom_data_in,
   output logic [18:0] sample_out,
   output logic        sample_valid_out,
   output logic        busy_out,
   output logic        overrun_out
);

   if (SAMPLE_DIV < 12 + ROM_LATENCY || ROM_LATENCY < 1) begin : g_param_check
      $error("voice_sequencer: SAMPLE_DIV must be >= 12+ROM_LATENCY and ROM_LATENCY >= 1");
   end

   localparam int DCW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

   seq_state_e                            state_q, state_d;
   logic [2:0]                            slot_q, slot_d;
   logic [DCW-1:0]                        drain_q, drain_d;
   logic [NUM_VOICES-1:0][PHASE_W-1:0]    phase_q, phase_d;
   logic [NUM_VOICES-1:0]                 pending_q, pending_d;
   logic [ROM_LATENCY-1:0]                tag_q, tag_d;
   logic [18:0]                           acc_q, acc_d;
   logic [18:0]                           sample_q, sample_d;
   logic                                  overrun_q, overrun_d;
   logic                                  tick;
   logic                                  restart;
   logic [PHASE_W-1:0]                    phase_upd;

   sample_tick_gen #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_tick (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .tick_out (tick)
   );

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      drain_d      = drain_q;
      phase_d      = phase_q;
      pending_d    = pending_q | trigger_in;
      acc_d        = acc_q;
      sample_d     = sample_q;
      overrun_d    = overrun_q | (tick && (state_q != ST_IDLE));
      rom_req_out  = 1'b0;
      rom_addr_out = '0;

      // A trigger arriving in the voice's own slot restarts it immediately.
      restart   = pending_q[slot_q] | trigger_in[slot_q];
      phase_upd = restart ? INC_TABLE[slot_q] : phase_q[slot_q] + INC_TABLE[slot_q];

      if (tag_q[ROM_LATENCY-1]) begin
         acc_d = acc_q + {{3{rom_data_in[15]}}, rom_data_in};
      end

      unique case (state_q)
         ST_IDLE: begin
            if (tick) begin
               state_d = ST_ISSUE;
               slot_d  = 3'd0;
               acc_d   = '0;
            end
         end
         ST_ISSUE: begin
            pending_d[slot_q] = 1'b0;
            if (gate_in[slot_q]) begin
               phase_d[slot_q] = phase_upd;
               rom_req_out     = 1'b1;
               rom_addr_out    = phase_upd[PHASE_W-1 -: 8];
            end else begin
               phase_d[slot_q] = '0;
            end
            if (slot_q == 3'd7) begin
               state_d = ST_DRAIN;
               drain_d = DCW'(ROM_LATENCY - 1);
            end else begin
               slot_d = slot_q + 3'd1;
            end
         end
         ST_DRAIN: begin
            // Load on the way into DONE so sample_out changes together with the valid pulse.
            if (drain_q == '0) begin
               state_d  = ST_DONE;
               sample_d = acc_d;
            end else begin
               drain_d = drain_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      tag_d[0] = rom_req_out;
      for (int i = 1; i < ROM_LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= ST_IDLE;
         slot_q    <= '0;
         drain_q   <= '0;
         phase_q   <= '0;
         pending_q <= '0;
         tag_q     <= '0;
         acc_q     <= '0;
         sample_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         slot_q    <= slot_d;
         drain_q   <= drain_d;
         phase_q   <= phase_d;
         pending_q <= pending_d;
         tag_q     <= tag_d;
         acc_q     <= acc_d;
         sample_q  <= sample_d;
         overrun_q <= overrun_d;
      end
   end

   assign sample_out       = sample_q;
   assign sample_valid_out = (state_q == ST_DONE);
   assign busy_out         = (state_q != ST_IDLE);
   assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Self-checking bench for voice_sequencer: frame vectors scored through a queue, plus phase, trigger and reset sequences.
module tb_voice_sequencer;

   localparam int SDIV = 14;
   localparam int RLAT = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        gate;
   logic [7:0]        trigger;
   logic              rom_req;
   logic [7:0]        rom_addr;
   logic [15:0]       rom_data;
   logic [18:0]       sample;
   logic              sample_valid;
   logic              busy;
   logic              overrun;

   logic signed [15:0] rom_val;
   logic               rom_p1;

   typedef struct {
      logic [7:0] gate;
      int         rom_val;
      int         exp_sample;
      int         exp_reqs;
   } vec_t;

   typedef struct {
      int sample;
      int reqs;
   } exp_t;

   vec_t   vecs[7];
   exp_t   exp_q[$];
   int     total = 0;
   int     bad   = 0;
   int     reqs_seen = 0;
   int     last_addr = 0;

   always #5 clk = ~clk;

   voice_sequencer #(
      .SAMPLE_DIV  (SDIV),
      .ROM_LATENCY (RLAT)
   ) dut (
      .clk_in           (clk),
      .rst_n_in         (rst_n),
      .gate_in          (gate),
      .trigger_in       (trigger),
      .rom_req_out      (rom_req),
      .rom_addr_out     (rom_addr),
      .rom_data_in      (rom_data),
      .sample_out       (sample),
      .sample_valid_out (sample_valid),
      .busy_out         (busy),
      .overrun_out      (overrun)
   );

   // ROM model: data valid two cycles after the request cycle, junk otherwise.
   always @(posedge clk) begin
      rom_p1   <= rom_req;
      rom_data <= rom_p1 ? rom_val : 16'h5A5A;
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard side: count requests per frame and score each published sample.
   always @(negedge clk) begin
      if (!rst_n) begin
         reqs_seen = 0;
      end else begin
         if (rom_req) begin
            reqs_seen++;
            last_addr = int'(rom_addr);
         end
         if (sample_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("frame_sample", longint'($signed(sample)), longint'(e.sample));
               check("frame_reqs", reqs_seen, e.reqs);
            end
            reqs_seen = 0;
         end
      end
   end

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sample_valid && n < 60);
      check("valid_arrived", sample_valid, 1);
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 100);
   endtask

   task automatic push_exp(input int s, input int r);
      exp_t e;
      e.sample = s;
      e.reqs   = r;
      exp_q.push_back(e);
   endtask

   initial begin
      int n;

      vecs[0] = '{gate: 8'h01, rom_val: 1000,   exp_sample: 1000,    exp_reqs: 1};
      vecs[1] = '{gate: 8'hFF, rom_val: -32768, exp_sample: -262144, exp_reqs: 8};
      vecs[2] = '{gate: 8'hFF, rom_val: 32767,  exp_sample: 262136,  exp_reqs: 8};
      vecs[3] = '{gate: 8'h00, rom_val: 1234,   exp_sample: 0,       exp_reqs: 0};
      vecs[4] = '{gate: 8'hA5, rom_val: -5,     exp_sample: -20,     exp_reqs: 4};
      vecs[5] = '{gate: 8'h80, rom_val: 7,      exp_sample: 7,       exp_reqs: 1};
      vecs[6] = '{gate: 8'h0F, rom_val: 300,    exp_sample: 1200,    exp_reqs: 4};

      // Reset held with all gates and triggers on.
      rst_n   = 1'b0;
      gate    = 8'hFF;
      trigger = 8'hFF;
      rom_val = 16'sd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("reset_outputs", {rom_req, rom_addr, sample, sample_valid, busy, overrun}, 0);
      end

      // First frame after release: first tick at count SDIV-1, valid 10 cycles after slot 0.
      trigger = 8'h00;
      gate    = 8'h01;
      rom_val = 16'sd1000;
      push_exp(1000, 1);
      rst_n = 1'b1;
      wait_busy(n);
      check("first_busy_cycles", n, SDIV);
      check("slot0_req", rom_req, 1);
      wait_valid(n);
      check("slot0_to_valid", n, 10);
      @(negedge clk);
      check("valid_one_cycle", sample_valid, 0);
      check("sample_held", longint'($signed(sample)), 1000);

      for (int i = 0; i < 7; i++) begin
         gate    = vecs[i].gate;
         rom_val = 16'(vecs[i].rom_val);
         push_exp(vecs[i].exp_sample, vecs[i].exp_reqs);
         wait_valid(n);
      end

      // Gate dropped for one frame clears the phase; re-raised voice restarts from INC[0].
      gate = 8'h00;
      push_exp(0, 0);
      wait_valid(n);
      gate    = 8'h01;
      rom_val = 16'sd1000;
      for (int f = 1; f <= 1494; f++) begin
         push_exp(1000, 1);
         wait_valid(n);
         if (f == 1)    check("restart_addr_f1", last_addr, 0);
         if (f == 1493) check("addr_f1493", last_addr, 0);
         if (f == 1494) check("addr_f1494", last_addr, 1);
      end

      // Trigger high only during slot 0 itself restarts the phase in that slot.
      push_exp(1000, 1);
      repeat (4) @(posedge clk);
      #1 trigger = 8'h01;
      check("slot0_during_trig", rom_req, 1);
      @(posedge clk);
      #1 trigger = 8'h00;
      wait_valid(n);
      check("trig_same_slot_addr", last_addr, 0);

      for (int f = 2; f <= 1494; f++) begin
         push_exp(1000, 1);
         wait_valid(n);
      end
      check("addr_again_1494", last_addr, 1);

      // Trigger pulse outside the slot is held pending until slot 0.
      @(negedge clk);
      trigger = 8'h01;
      @(negedge clk);
      trigger = 8'h00;
      push_exp(1000, 1);
      wait_valid(n);
      check("trig_pending_addr", last_addr, 0);

      // Reset during ISSUE slot 4 aborts the frame.
      gate    = 8'hFF;
      rom_val = 16'sd100;
      push_exp(800, 8);
      repeat (8) @(posedge clk);
      #1;
      check("pre_reset_busy_req", {busy, rom_req}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("midframe_reset_outs", {rom_req, rom_addr, sample, sample_valid, busy, overrun}, 0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push_exp(800, 8);
      wait_busy(n);
      check("post_reset_first_busy", n, SDIV);
      wait_valid(n);
      check("post_reset_latency", n, 10);

      @(negedge clk);
      check("no_overrun", overrun, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/voice_sequencer.md
VOICE_SEQUENCER -- requirements
Module: voice_sequencer

Interface
REQ-001 Parameter SAMPLE_DIV, default 6104, clk_in cycles per output sample (≈16.384 kHz at 100 MHz).
REQ-002 Parameter ROM_LATENCY, default 2, fixed cycles from rom_req_out to valid rom_data_in.
REQ-003 clk_in  in  1  system clock; all state on rising edge.
REQ-004 rst_n_in  in  1  reset, asynchronous, active-low.
REQ-005 gate_in  in  8  per-voice note held; bit i = voice i.
REQ-006 trigger_in  in  8  per-voice phase restart request, level or pulse.
REQ-007 rom_req_out  out  1  shared sine ROM read strobe.
REQ-008 rom_addr_out  out  8  ROM address = phase[31:24] of the serviced voice.
REQ-009 rom_data_in  in  16  signed ROM sample, valid ROM_LATENCY cycles after its request.
REQ-010 sample_out  out  19  signed mixed sample, held between updates.
REQ-011 sample_valid_out  out  1  one-cycle pulse when sample_out updates.
REQ-012 busy_out  out  1  high whenever FSM is not IDLE.
REQ-013 overrun_out  out  1  sticky flag: tick arrived while busy.

Function
REQ-014 Divider counts 0..SAMPLE_DIV-1, wraps, and pulses tick for one cycle at SAMPLE_DIV-1; free-running, independent of FSM.
REQ-015 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on tick; ISSUE lasts exactly 8 cycles (slot v = voice v, v=0..7); ISSUE->DRAIN; DRAIN lasts ROM_LATENCY cycles; DRAIN->DONE; DONE->IDLE after one cycle.
REQ-016 In slot v with gate_in[v]=1: phase[v] <= phase[v]+INC[v] (mod 2^32, wrap silently); rom_req_out=1; rom_addr_out = bits[31:24] of the updated phase.
REQ-017 In slot v with gate_in[v]=0: phase[v] <= 0; rom_req_out=0; rom_addr_out=0; voice contributes nothing.
REQ-018 Any cycle with trigger_in[v]=1 sets pending[v]; in slot v with pending[v]=1 and gate_in[v]=1 the update is phase[v] <= INC[v]; pending[v] cleared in slot v regardless of gate.
REQ-019 trigger_in[v] high in the same cycle as slot v counts as pending for that slot.
REQ-020 A valid tag pipeline of ROM_LATENCY stages follows each request; tagged returns are sign-extended to 19 bits and added to the accumulator; untagged cycles add nothing.
REQ-021 Accumulator cleared on entry to ISSUE; no saturation (8 x 16-bit signed fits 19 bits).
REQ-022 In DONE: sample_out <= accumulator, sample_valid_out=1; tick-to-valid latency = 9+ROM_LATENCY cycles (tick at T, valid at T+9+ROM_LATENCY).
REQ-023 Tick while busy_out=1: tick ignored, current frame completes, overrun_out set until reset.
REQ-024 gate_in sampled only in its own slot; changes outside the slot take effect next frame.

Reset
REQ-025 rst_n_in low: immediately FSM=IDLE, divider=0, all phase and pending=0, accumulator and tag pipeline cleared, all outputs 0.
REQ-026 Reset asserted mid-frame aborts the frame; no sample_valid_out for it; first tick after release occurs at divider count SAMPLE_DIV-1.

Structure
REQ-027 Package synth_pkg holds NUM_VOICES=8, PHASE_W=32, INC table {11237,12613,14157,14999,16836,18898,21212,22473}, and FSM state enum.
REQ-028 One sub-module sample_tick_gen (divider, REQ-014); phase registers, FSM, and mixer reside in voice_sequencer.
REQ-029 Elaboration check: SAMPLE_DIV >= 12+ROM_LATENCY.

Verification
REQ-030 Reset: hold rst_n_in low 5 cycles with gates on -> all outputs 0, no rom_req_out.
REQ-031 gate_in=8'h01, ROM model returns 16'sd1000 -> one request per frame in slot 0, sample_out=1000 pulsed at T+11 (ROM_LATENCY=2).
REQ-032 gate_in=8'hFF, ROM returns -32768 -> 8 requests per frame, sample_out=-262144 with no wrap.
REQ-033 gate_in=8'h01 for 1500 frames -> rom_addr_out=1; pulse trigger_in[0] -> next frame rom_addr_out=0, phase restarted at 11237.
REQ-034 Drop gate_in[0] for one frame -> no request in slot 0, sample_out=0; re-raise -> phase restarts at 11237.
REQ-035 SAMPLE_DIV=14, ROM_LATENCY=2, reset pulsed during ISSUE slot 4 -> outputs 0 at once, no valid for aborted frame, first tick 13 cycles after release.
